xor_fenwick_regfile: RTL and testbench

- Parametrised successor to the 8-entry 1-bit XOR register bank.
- Holds DEPTH elements of WIDTH bits in a Fenwick (binary indexed) tree of XOR partial sums.
- Supports three command types: point XOR-update, arbitrary range-XOR query, and clear.
- Works as a multi-cycle engine behind a valid/ready command port and a valid/ready response port. It sits between the instruction decoder and the datapath that consumes range XORs.

---
 rtl/xor_fenwick_regfile_if.sv | 32 +++
 rtl/xor_fenwick_regfile.sv | 197 +++++++++++++++++++
 tb/tb_xor_fenwick_regfile.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/xor_fenwick_regfile_if.sv
// Command/response bundle for xor_fenwick_regfile.
// The interface adds no latency: it is wiring only.
// The engine drives cmd_ready and rsp_valid. The consumer drives cmd_valid and rsp_ready.
// Ports:
//    master = command source / response consumer
//    slave  = the engine
interface xor_fenwick_regfile_if #(
   parameter int WIDTH = 1,
   parameter int AW    = 3
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [AW-1:0]    cmd_lo;
   logic [AW-1:0]    cmd_hi;
   logic [WIDTH-1:0] cmd_val;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_data;
   logic             rsp_err;
   logic             busy;

   modport master (
      output cmd_valid, cmd_op, cmd_lo, cmd_hi, cmd_val, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_data, rsp_err, busy
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_lo, cmd_hi, cmd_val, rsp_ready,
      output cmd_ready, rsp_valid, rsp_data, rsp_err, busy
   );
endinterface

// File: rtl/xor_fenwick_regfile.sv
// Purpose: DEPTH x WIDTH element bank held as a Fenwick tree of XOR partial sums.
//    Commands are point XOR-update, range-XOR query and clear.
// Latency:
//    UPDATE: 1..log2(DEPTH)+1 cycles, one tree node per cycle.
//    QUERY:  up to 2*(log2(DEPTH)+1)+1 cycles to rsp_valid.
//    CLEAR:  completes on the acceptance edge.
// Backpressure:
//    cmd_ready is high only when the engine is IDLE.
//    A response is held stable in RESP until rsp_ready is seen.
// Ports:
//    clk, rst : clock and synchronous active-high reset.
//    bus      : slave modport of xor_fenwick_regfile_if.
//       cmd_*   carry the command.
//       rsp_*   carry the response.
//       busy    is high whenever the engine is not IDLE.
// Optional build macro:
//    XOR_FENWICK_SHADOW_EN adds a flat element shadow array and enables op 3 (READ).
module xor_fenwick_regfile #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 8
) (
   input logic                 clk,
   input logic                 rst,
   xor_fenwick_regfile_if.slave bus
);
   localparam int AW = $clog2(DEPTH);

   localparam logic [1:0] OP_UPDATE = 2'd0;
   localparam logic [1:0] OP_QUERY  = 2'd1;
   localparam logic [1:0] OP_CLEAR  = 2'd2;
   localparam logic [1:0] OP_READ   = 2'd3;

   typedef enum logic [2:0] {IDLE, UPD, QHI, QLO, RESP} state_t;

   state_t           st_q, st_d;
   logic [AW:0]      k_q, k_d;          // tree index 1..DEPTH; needs AW+1 bits
   logic [AW-1:0]    lo_q, lo_d;        // low query bound, held for the QLO walk
   logic [WIDTH-1:0] v_q, v_d;          // UPDATE value
   logic [WIDTH-1:0] acc_q, acc_d;      // running query XOR
   logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic             rsp_err_q, rsp_err_d;
   // node_q[i] holds tree node k = i+1
   logic [WIDTH-1:0] node_q [DEPTH];
   logic [WIDTH-1:0] node_d [DEPTH];
`ifdef XOR_FENWICK_SHADOW_EN
   logic [WIDTH-1:0] elem_q [DEPTH];
   logic [WIDTH-1:0] elem_d [DEPTH];
`endif

   logic [AW:0]      lb;                // lowbit(k)
   logic [AW-1:0]    nidx;              // storage slot of node k
   logic [AW+1:0]    k_up;              // k + lowbit(k), one extra bit so it cannot wrap
   logic [AW:0]      k_dn;              // k - lowbit(k)
   logic [WIDTH-1:0] acc_x;             // acc with the current node folded in

   always_comb begin
      st_d       = st_q;
      k_d        = k_q;
      lo_d       = lo_q;
      v_d        = v_q;
      acc_d      = acc_q;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;
      node_d     = node_q;
`ifdef XOR_FENWICK_SHADOW_EN
      elem_d     = elem_q;
`endif
      lb    = k_q & (~k_q + (AW+1)'(1));
      // k in 1..DEPTH maps to slot (k-1) mod DEPTH. That is exactly k-1,
      // because k=DEPTH wraps to DEPTH-1 in AW bits.
      nidx  = k_q[AW-1:0] - AW'(1);
      k_up  = {1'b0, k_q} + {1'b0, lb};
      k_dn  = k_q - lb;
      acc_x = acc_q ^ node_q[nidx];

      case (st_q)
         IDLE: begin
            if (bus.cmd_valid) begin
               case (bus.cmd_op)
                  OP_UPDATE: begin
                     k_d  = {1'b0, bus.cmd_lo} + (AW+1)'(1);
                     v_d  = bus.cmd_val;
                     st_d = UPD;
`ifdef XOR_FENWICK_SHADOW_EN
                     elem_d[bus.cmd_lo] = elem_q[bus.cmd_lo] ^ bus.cmd_val;
`endif
                  end
                  OP_QUERY: begin
                     if (bus.cmd_lo > bus.cmd_hi) begin
                        rsp_data_d = '0;
                        rsp_err_d  = 1'b1;
                        st_d       = RESP;
                     end else begin
                        acc_d = '0;
                        k_d   = {1'b0, bus.cmd_hi} + (AW+1)'(1);
                        lo_d  = bus.cmd_lo;
                        st_d  = QHI;
                     end
                  end
                  OP_CLEAR: begin
                     node_d = '{default: '0};
`ifdef XOR_FENWICK_SHADOW_EN
                     elem_d = '{default: '0};
`endif
                  end
                  OP_READ: begin
`ifdef XOR_FENWICK_SHADOW_EN
                     rsp_data_d = elem_q[bus.cmd_lo];
                     rsp_err_d  = 1'b0;
`else
                     rsp_data_d = '0;
                     rsp_err_d  = 1'b1;
`endif
                     st_d = RESP;
                  end
                  default: st_d = IDLE;
               endcase
            end
         end
         UPD: begin
            node_d[nidx] = node_q[nidx] ^ v_q;
            if (k_up > (AW+2)'(DEPTH)) begin
               st_d = IDLE;
            end else begin
               k_d = k_up[AW:0];
            end
         end
         QHI: begin
            // Prefix XOR over elements 0..hi.
            acc_d = acc_x;
            if (k_dn == '0) begin
               if (lo_q == '0) begin
                  rsp_data_d = acc_x;
                  rsp_err_d  = 1'b0;
                  st_d       = RESP;
               end else begin
                  k_d  = {1'b0, lo_q};
                  st_d = QLO;
               end
            end else begin
               k_d = k_dn;
            end
         end
         QLO: begin
            // Fold out the prefix over elements 0..lo-1.
            acc_d = acc_x;
            if (k_dn == '0) begin
               rsp_data_d = acc_x;
               rsp_err_d  = 1'b0;
               st_d       = RESP;
            end else begin
               k_d = k_dn;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               st_d = IDLE;
            end
         end
         default: st_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q       <= IDLE;
         k_q        <= '0;
         lo_q       <= '0;
         v_q        <= '0;
         acc_q      <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
         node_q     <= '{default: '0};
`ifdef XOR_FENWICK_SHADOW_EN
         elem_q     <= '{default: '0};
`endif
      end else begin
         st_q       <= st_d;
         k_q        <= k_d;
         lo_q       <= lo_d;
         v_q        <= v_d;
         acc_q      <= acc_d;
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
         node_q     <= node_d;
`ifdef XOR_FENWICK_SHADOW_EN
         elem_q     <= elem_d;
`endif
      end
   end

   assign bus.cmd_ready = (st_q == IDLE);
   assign bus.rsp_valid = (st_q == RESP);
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.busy      = (st_q != IDLE);
endmodule

// File: tb/tb_xor_fenwick_regfile.sv
// Self-checking bench for xor_fenwick_regfile (DEPTH=8, WIDTH=4).
// Expected responses come from a flat element array and are queued at issue.
// An independent monitor pops and compares them on every response handshake.
module tb_xor_fenwick_regfile;
   localparam int WIDTH = 4;
   localparam int DEPTH = 8;
   localparam int AW    = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   xor_fenwick_regfile_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

   xor_fenwick_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic             err;
   } exp_t;

   exp_t             exp_q[$];
   logic [WIDTH-1:0] model [DEPTH];
   int               n_checks = 0;
   int               n_fail   = 0;
   bit               rand_rdy = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Response monitor: one pop per handshake.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst === 1'b0 && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_rsp: got data 0x%0h err %0b, expected no response",
                     bus.rsp_data, bus.rsp_err);
         end else begin
            e = exp_q.pop_front();
            check("rsp_data", 32'(bus.rsp_data), 32'(e.data));
            check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   function automatic exp_t ref_query(input int lo, input int hi);
      exp_t e;
      e.data = '0;
      e.err  = 1'b0;
      if (lo > hi) e.err = 1'b1;
      else for (int i = lo; i <= hi; i++) e.data ^= model[i];
      return e;
   endfunction

   function automatic exp_t ref_read(input int idx);
      exp_t e;
`ifdef XOR_FENWICK_SHADOW_EN
      e.data = model[idx];
      e.err  = 1'b0;
`else
      e.data = '0;
      e.err  = 1'b1;
      if (idx < 0) e.err = 1'b1;
`endif
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (bus.cmd_ready !== 1'b1 && n < 200) begin
         if (rand_rdy) bus.rsp_ready = 1'($urandom_range(0, 1));
         tick();
         n++;
      end
      check("cmd_ready_wait", 32'(bus.cmd_ready), 32'(1));
   endtask

   // Drives one command and is accepted on the next edge. The reference model is updated at issue.
   task automatic issue(input logic [1:0] op, input int lo, input int hi, input logic [WIDTH-1:0] val);
      wait_ready();
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_lo    = AW'(lo);
      bus.cmd_hi    = AW'(hi);
      bus.cmd_val   = val;
      case (op)
         2'd0: model[lo] ^= val;
         2'd1: exp_q.push_back(ref_query(lo, hi));
         2'd2: for (int i = 0; i < DEPTH; i++) model[i] = '0;
         default: exp_q.push_back(ref_read(lo));
      endcase
      tick();
      bus.cmd_valid = 1'b0;
      // Junk on the command fields while busy must be ignored.
      bus.cmd_op    = 2'($urandom);
      bus.cmd_lo    = AW'($urandom);
      bus.cmd_hi    = AW'($urandom);
      bus.cmd_val   = WIDTH'($urandom);
   endtask

   task automatic count_busy(output int n);
      n = 0;
      while (bus.cmd_ready !== 1'b1 && n < 40) begin
         n++;
         tick();
      end
   endtask

   initial begin
      int   n;
      exp_t bp;
      rst           = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = '0;
      bus.cmd_lo    = '0;
      bus.cmd_hi    = '0;
      bus.cmd_val   = '0;
      bus.rsp_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      repeat (3) tick();

      check("rst_cmd_ready", 32'(bus.cmd_ready), 32'(1));
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
      check("rst_rsp_data", 32'(bus.rsp_data), 32'(0));
      check("rst_rsp_err", 32'(bus.rsp_err), 32'(0));
      check("rst_busy", 32'(bus.busy), 32'(0));
      rst = 1'b0;

      issue(2'd1, 0, 7, '0);

      // Basic ranges.
      issue(2'd0, 3, 0, 4'hA);
      issue(2'd0, 5, 0, 4'h6);
      issue(2'd1, 0, 7, '0);
      issue(2'd1, 4, 7, '0);
      issue(2'd1, 3, 3, '0);
      issue(2'd1, 0, 2, '0);
      wait_ready();
      check("model_sanity_0_7", 32'(ref_query(0, 7).data), 32'(4'hC));

      // Update latency in node visits.
      issue(2'd0, 0, 0, 4'h1);
      count_busy(n);
      check("upd0_latency", 32'(n), 32'(4));
      issue(2'd0, 7, 0, 4'h1);
      count_busy(n);
      check("upd7_latency", 32'(n), 32'(1));

      // Illegal bounds and op 3: the response follows acceptance by one cycle.
      issue(2'd1, 5, 2, '0);
      check("illegal_rsp_valid_1cyc", 32'(bus.rsp_valid), 32'(1));
      check("illegal_busy", 32'(bus.busy), 32'(1));
      issue(2'd3, 2, 0, '0);
      check("op3_rsp_valid_1cyc", 32'(bus.rsp_valid), 32'(1));

      // Backpressure.
      wait_ready();
      bus.rsp_ready = 1'b0;
      bp = ref_query(1, 6);
      issue(2'd1, 1, 6, '0);
      n = 0;
      while (bus.rsp_valid !== 1'b1 && n < 40) begin
         n++;
         tick();
      end
      check("bp_rsp_arrives", 32'(bus.rsp_valid), 32'(1));
      for (int c = 0; c < 3; c++) begin
         tick();
         check("bp_valid_hold", 32'(bus.rsp_valid), 32'(1));
         check("bp_data_hold", 32'(bus.rsp_data), 32'(bp.data));
         check("bp_err_hold", 32'(bus.rsp_err), 32'(bp.err));
         check("bp_cmd_ready_low", 32'(bus.cmd_ready), 32'(0));
      end
      bus.rsp_ready = 1'b1;
      tick();
      check("bp_released_valid", 32'(bus.rsp_valid), 32'(0));
      check("bp_released_ready", 32'(bus.cmd_ready), 32'(1));

      // Reset in the middle of an update.
      issue(2'd0, 0, 0, 4'hF);
      check("mid_upd_busy", 32'(bus.busy), 32'(1));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      check("post_rst_busy", 32'(bus.busy), 32'(0));
      issue(2'd1, 0, 7, '0);

      // Clear, and read-back through op 3.
      issue(2'd0, 2, 0, 4'h5);
      issue(2'd3, 2, 0, '0);
      issue(2'd2, 0, 0, '0);
      check("clear_stays_idle", 32'(bus.cmd_ready), 32'(1));
      issue(2'd1, 0, 7, '0);

      // Randomised mix with random response backpressure.
      rand_rdy = 1'b1;
      for (int t = 0; t < 120; t++) begin
         int r;
         r = int'($urandom_range(0, 9));
         if (r < 4)       issue(2'd0, int'($urandom_range(0, 7)), 0, WIDTH'($urandom));
         else if (r < 8)  issue(2'd1, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), '0);
         else if (r == 8) issue(2'd3, int'($urandom_range(0, 7)), 0, '0);
         else             issue(2'd2, 0, 0, '0);
      end
      rand_rdy      = 1'b0;
      bus.rsp_ready = 1'b1;
      wait_ready();
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         n++;
         tick();
      end
      check("scoreboard_drained", 32'(exp_q.size()), 32'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
